// File: rtl/issue_fifo.sv
// issue_fifo: prefetch buffer between fetch and decode using trigger/ready toggle handshakes.
// Defining ISSUE_FIFO_SYNC_EN adds 2-flop synchronizers on readyIn and triggerIn.
module issue_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             triggerOut,
  input  logic             readyIn,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             triggerIn,
  output logic             readyOut,
  output logic [WIDTH-1:0] dataOut,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t           state_q, state_d;
  logic             trigger_out_q, trigger_out_d;
  logic             ready_out_q, ready_out_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             ready_in_s;
  logic             trigger_in_s;
  logic             ack;
  logic             pending;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count_next;

`ifdef ISSUE_FIFO_SYNC_EN
  logic [1:0] ready_sync_q, ready_sync_d;
  logic [1:0] trigger_sync_q, trigger_sync_d;

  always_comb begin
    ready_sync_d   = {ready_sync_q[0], readyIn};
    trigger_sync_d = {trigger_sync_q[0], triggerIn};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_sync_q   <= '0;
      trigger_sync_q <= '0;
    end else begin
      ready_sync_q   <= ready_sync_d;
      trigger_sync_q <= trigger_sync_d;
    end
  end

  assign ready_in_s   = ready_sync_q[1];
  assign trigger_in_s = trigger_sync_q[1];
`else
  assign ready_in_s   = readyIn;
  assign trigger_in_s = triggerIn;
`endif

  always_comb begin
    ack        = (ready_in_s == trigger_out_q);
    pending    = (trigger_in_s != ready_out_q);
    pop        = pending && (count_q != '0) && !flush;
    push       = (state_q == WAIT) && ack && !flush;
    count_next = count_q + CW'(push) - CW'(pop);

    state_d       = state_q;
    trigger_out_d = trigger_out_q;
    ready_out_d   = ready_out_q;
    data_out_d    = data_out_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_d         = mem_q;

    // Only one fetch request is ever outstanding; room is checked before each toggle.
    case (state_q)
      IDLE: begin
        if (!flush && (count_q < CW'(DEPTH))) begin
          trigger_out_d = ~trigger_out_q;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (ack) begin
          if (!flush && (count_next < CW'(DEPTH))) begin
            trigger_out_d = ~trigger_out_q;
          end else begin
            state_d = IDLE;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = dataIn;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      data_out_d  = mem_q[rd_ptr_q];
      ready_out_d = trigger_in_s;
      rd_ptr_d    = rd_ptr_q + AW'(1);
    end

    // A redirect empties the buffer but leaves the last response to decode untouched.
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      trigger_out_q <= 1'b0;
      ready_out_q   <= 1'b0;
      data_out_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      trigger_out_q <= trigger_out_d;
      ready_out_q   <= ready_out_d;
      data_out_q    <= data_out_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign triggerOut = trigger_out_q;
  assign readyOut   = ready_out_q;
  assign dataOut    = data_out_q;
  assign count      = count_q;

endmodule

// File: tb/tb_issue_fifo.sv
// tb_issue_fifo: directed scenarios plus random traffic, checked against a queue model of the buffer.
module tb_issue_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef ISSUE_FIFO_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  typedef struct {
    int               edge_no;
    logic [WIDTH-1:0] data;
  } ack_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             triggerOut;
  logic             readyIn = 1'b0;
  logic [WIDTH-1:0] dataIn = '0;
  logic             triggerIn = 1'b0;
  logic             readyOut;
  logic [WIDTH-1:0] dataOut;
  logic             flush = 1'b0;
  logic [CW-1:0]    count;

  int compared = 0;
  int mismatched = 0;

  bit               fetch_en = 1'b0;
  int               fetch_delay = 1;
  int               wait_cnt = 0;
  bit               outstanding = 1'b0;
  bit               req_flushed = 1'b0;
  int               toggles = 0;
  logic             last_trig = 1'b0;
  logic [WIDTH-1:0] next_data = 32'h100;
  logic [WIDTH-1:0] data_q [$];
  ack_t             ack_q [$];
  int               edge_n = 0;

  logic [WIDTH-1:0] model_q [$];
  logic             rdy_phase = 1'b0;
  logic [WIDTH-1:0] exp_data = '0;
  logic [1:0]       tin_p = '0;

  issue_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .triggerOut(triggerOut),
    .readyIn   (readyIn),
    .dataIn    (dataIn),
    .triggerIn (triggerIn),
    .readyOut  (readyOut),
    .dataOut   (dataOut),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (readyOut !== triggerIn && n < 60) begin
      @(negedge clk);
      n++;
    end
    compared++;
    assert (readyOut === triggerIn) else begin
      mismatched++;
      $error("[TB] FAIL %s timeout readyOut=%b expected=%b", tag, readyOut, triggerIn);
    end
  endtask

  task automatic waitCount(input string tag, input int target);
    int n = 0;
    while (int'(count) != target && n < 100) begin
      @(negedge clk);
      n++;
    end
    compared++;
    assert (int'(count) == target) else begin
      mismatched++;
      $error("[TB] FAIL %s timeout count=%0d expected=%0d", tag, count, target);
    end
  endtask

  // Fetch side: acks each request after fetch_delay cycles and logs when the DUT should accept it.
  initial forever begin
    ack_t a;
    @(posedge clk);
    #2;
    if (!reset) begin
      readyIn     = 1'b0;
      outstanding = 1'b0;
      wait_cnt    = 0;
      toggles     = 0;
      last_trig   = 1'b0;
      ack_q.delete();
    end else begin
      if (triggerOut !== last_trig) begin
        toggles++;
        last_trig = triggerOut;
      end
      if (!outstanding && triggerOut !== readyIn) begin
        outstanding = 1'b1;
        wait_cnt    = 0;
      end
      if (outstanding && fetch_en && triggerOut !== readyIn) begin
        if (wait_cnt >= fetch_delay) begin
          if (data_q.size() > 0) begin
            dataIn = data_q.pop_front();
          end else begin
            dataIn    = next_data;
            next_data = next_data + 32'd4;
          end
          readyIn   = triggerOut;
          a.edge_no = edge_n + 1 + L;
          a.data    = dataIn;
          ack_q.push_back(a);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Reference model: an ordered queue of accepted words; flushes discard buffered and in-flight words.
  initial forever begin
    ack_t a;
    bit   accept;
    logic tin_s;
    @(posedge clk);
    #1;
    edge_n++;
    if (!reset) begin
      model_q.delete();
      ack_q.delete();
      outstanding = 1'b0;
      req_flushed = 1'b0;
      rdy_phase   = 1'b0;
      exp_data    = '0;
      tin_p       = '0;
    end else begin
      tin_s  = (L == 0) ? triggerIn : tin_p[1];
      tin_p  = {tin_p[0], triggerIn};
      accept = 1'b0;
      if (outstanding && flush) req_flushed = 1'b1;
      if (ack_q.size() > 0 && ack_q[0].edge_no == edge_n) begin
        a           = ack_q.pop_front();
        accept      = !req_flushed;
        outstanding = 1'b0;
        req_flushed = 1'b0;
      end
      if (flush) begin
        model_q.delete();
      end else begin
        if (tin_s != rdy_phase && model_q.size() > 0) begin
          exp_data  = model_q.pop_front();
          rdy_phase = tin_s;
        end
        if (accept) model_q.push_back(a.data);
      end
    end
    checkOutput("model_count", count, model_q.size());
    checkOutput("model_readyOut", readyOut, rdy_phase);
    checkOutput("model_dataOut", dataOut, exp_data);
  end

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      fetch_delay = $urandom_range(0, 3);
      if (readyOut === triggerIn && $urandom_range(0, 1) == 1) triggerIn = ~triggerIn;
      flush = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    logic old_phase;
    $display("[TB] start, handshake latency L=%0d", L);
    fetch_en    = 1'b1;
    fetch_delay = 1;
    repeat (3) @(negedge clk);
    checkOutput("rst_triggerOut", triggerOut, 0);
    checkOutput("rst_readyOut", readyOut, 0);
    checkOutput("rst_dataOut", dataOut, 0);
    checkOutput("rst_count", count, 0);

    reset = 1'b1;
    @(negedge clk);
    checkOutput("first_request", triggerOut, 1);
    repeat (40) @(negedge clk);
    checkOutput("fill_toggles", toggles, 4);
    checkOutput("fill_count", count, 4);
    repeat (10) @(negedge clk);
    checkOutput("no_fifth_toggle", toggles, 4);

    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      triggerIn = ~triggerIn;
      waitReady("drain_wait");
      checkOutput($sformatf("drain_word%0d", i), dataOut, 32'h100 + 32'(4 * i));
    end
    checkOutput("drain_count", count, 0);
    checkOutput("refill_request", toggles, 5);

    old_phase = triggerIn;
    triggerIn = ~triggerIn;
    data_q.push_back(32'hE3A00001);
    repeat (5) @(negedge clk);
    checkOutput("empty_hold", readyOut, old_phase);
    fetch_delay = 0;
    fetch_en    = 1'b1;
    waitCount("empty_write", 1);
    checkOutput("empty_not_yet", readyOut, old_phase);
    @(negedge clk);
    checkOutput("empty_ready", readyOut, triggerIn);
    checkOutput("empty_data", dataOut, 32'hE3A00001);

    flush = 1'b1;
    @(negedge clk);
    flush       = 1'b0;
    fetch_delay = 1;
    waitCount("simul_fill", 2);
    fetch_delay = 0;
    @(negedge clk);
    triggerIn = ~triggerIn;
    repeat (1 + L) @(negedge clk);
    checkOutput("simul_count", count, 2);
    checkOutput("simul_ready", readyOut, triggerIn);

    fetch_delay = 1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    waitCount("flush_fill", 3);
    fetch_en = 1'b0;
    data_q.delete();
    data_q.push_back(32'hDEAD);
    data_q.push_back(32'h200);
    next_data = 32'h204;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_count", count, 0);
    fetch_delay = 0;
    fetch_en    = 1'b1;
    triggerIn   = ~triggerIn;
    waitReady("flush_wait");
    checkOutput("flush_first_word", dataOut, 32'h200);

    fetch_delay = 1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    waitCount("reset_fill", 3);
    fetch_en  = 1'b0;
    reset     = 1'b0;
    triggerIn = 1'b0;
    @(negedge clk);
    checkOutput("midrst_triggerOut", triggerOut, 0);
    checkOutput("midrst_readyOut", readyOut, 0);
    checkOutput("midrst_dataOut", dataOut, 0);
    checkOutput("midrst_count", count, 0);
    reset     = 1'b1;
    next_data = 32'h300;
    fetch_en  = 1'b1;
    @(negedge clk);
    checkOutput("restart_request", triggerOut, 1);
    repeat (40) @(negedge clk);
    checkOutput("restart_count", count, 4);
    checkOutput("restart_toggles", toggles, 4);
    triggerIn = ~triggerIn;
    waitReady("restart_wait");
    checkOutput("restart_first_word", dataOut, 32'h300);

    applyStimulus(400);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
